// File: rtl/pw_pkg.sv
// Shared types and widths for the boot loader: state encoding and bus widths.
package pw_pkg;
  localparam int ADR_W  = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } pw_state_e;
endpackage

// File: rtl/pw_load_timer.sv
// Idle-cycle watchdog for the LOAD phase: counts enabled cycles since the last clear
// and flags the cycle on which the count reaches TIMEOUT_CYC.
module pw_load_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Asserted during the TIMEOUT_CYC-th consecutive idle cycle, so the state moves on that edge.
  assign expire = en && !clr && (cnt_q == 16'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/pw_boot_loader.sv
// Boot loader: streams LenIn bytes from a byte handshake into memory at BASE_ADR,
// then releases the CPU and passes its memory requests straight through.
module pw_boot_loader
  import pw_pkg::*;
#(
  parameter logic [ADR_W-1:0] BASE_ADR    = 16'h0000,
  parameter int               TIMEOUT_CYC = 1024
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  input  logic              Stop,
  input  logic [15:0]       LenIn,
  input  logic              RxValid,
  input  logic [DATA_W-1:0] RxData,
  output logic              RxReady,
  input  logic              CpuLdMem,
  input  logic              CpuWrtMem,
  input  logic [ADR_W-1:0]  CpuAdr,
  input  logic [DATA_W-1:0] CpuData,
  output logic [ADR_W-1:0]  MemAdr,
  output logic [DATA_W-1:0] MemWData,
  output logic              MemRe,
  output logic              MemWe,
  output logic              CpuEn,
  output logic              Busy,
  output logic              Error
);
  pw_state_e         state_q, state_d;
  logic [15:0]       rem_q, rem_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              bufv_q, bufv_d;

  logic in_load, rx_xfer, wr, tmr_expire;

  assign in_load = (state_q == ST_LOAD);
  assign rx_xfer = in_load && !bufv_q && RxValid;
  // A Stop in the write cycle aborts the load, so the buffered byte is dropped, not written.
  assign wr      = in_load && bufv_q && !Stop;

  pw_load_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (Clk),
    .rst    (Rst),
    .clr    (!in_load || rx_xfer),
    .en     (in_load && !rx_xfer),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    adr_d   = adr_q;
    buf_d   = buf_q;
    bufv_d  = bufv_q;
    if (Start && !in_load) begin
      bufv_d = 1'b0;
      if (LenIn == '0) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_LOAD;
        rem_d   = LenIn;
        adr_d   = BASE_ADR;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (Stop) begin
            state_d = ST_IDLE;
            bufv_d  = 1'b0;
          end else if (wr) begin
            adr_d  = adr_q + 16'd1;
            rem_d  = rem_q - 16'd1;
            bufv_d = 1'b0;
            if (rem_q == 16'd1) state_d = ST_RUN;
          end else if (rx_xfer) begin
            buf_d  = RxData;
            bufv_d = 1'b1;
          end else if (tmr_expire) begin
            state_d = ST_ERR;
            bufv_d  = 1'b0;
          end
        end
        ST_RUN:  if (Stop) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      adr_q   <= '0;
      buf_q   <= '0;
      bufv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      adr_q   <= adr_d;
      buf_q   <= buf_d;
      bufv_q  <= bufv_d;
    end
  end

  always_comb begin
    MemAdr   = '0;
    MemWData = '0;
    MemRe    = 1'b0;
    MemWe    = 1'b0;
    if (state_q == ST_RUN) begin
      MemAdr   = CpuAdr;
      MemWData = CpuData;
      MemRe    = CpuLdMem;
      MemWe    = CpuWrtMem;
    end else if (wr) begin
      MemAdr   = adr_q;
      MemWData = buf_q;
      MemWe    = 1'b1;
    end
  end

  assign RxReady = in_load && !bufv_q;
  assign CpuEn   = (state_q == ST_RUN);
  assign Busy    = in_load;
  assign Error   = (state_q == ST_ERR);
endmodule

// File: tb/tb_pw_boot_loader.sv
// Directed plus randomized bench for pw_boot_loader against a behavioural load model.
module tb_pw_boot_loader;
  localparam logic [15:0] BASE = 16'hFFFE;
  localparam int          TO   = 8;

  logic        Clk = 1'b0, Rst = 1'b1, Start = 1'b0, Stop = 1'b0;
  logic [15:0] LenIn = '0;
  logic        RxValid = 1'b0;
  logic [7:0]  RxData = '0;
  logic        RxReady;
  logic        CpuLdMem = 1'b0, CpuWrtMem = 1'b0;
  logic [15:0] CpuAdr = '0;
  logic [7:0]  CpuData = '0;
  logic [15:0] MemAdr;
  logic [7:0]  MemWData;
  logic        MemRe, MemWe, CpuEn, Busy, Error;

  int checks = 0, failures = 0;

  pw_boot_loader #(.BASE_ADR(BASE), .TIMEOUT_CYC(TO)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .LenIn(LenIn),
    .RxValid(RxValid), .RxData(RxData), .RxReady(RxReady),
    .CpuLdMem(CpuLdMem), .CpuWrtMem(CpuWrtMem), .CpuAdr(CpuAdr), .CpuData(CpuData),
    .MemAdr(MemAdr), .MemWData(MemWData), .MemRe(MemRe), .MemWe(MemWe),
    .CpuEn(CpuEn), .Busy(Busy), .Error(Error)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: what the loader is doing, how many bytes remain, where the next one goes.
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_ERR} mode_e;
  mode_e      m_mode;
  int         m_left, m_next_adr, m_quiet;
  bit         m_have;
  logic [7:0] m_byte;

  typedef struct { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t obs_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_next_adr = 0; m_quiet = 0; m_have = 0; m_byte = '0;
  endtask

  task automatic check_outputs();
    logic [15:0] ea;
    logic [7:0]  ed;
    logic        ere, ewe;
    ea = '0; ed = '0; ere = 1'b0; ewe = 1'b0;
    if (m_mode == M_RUN) begin
      ea = CpuAdr; ed = CpuData; ere = CpuLdMem; ewe = CpuWrtMem;
    end else if (m_mode == M_LOAD && m_have && !Stop) begin
      ea = m_next_adr[15:0]; ed = m_byte; ewe = 1'b1;
    end
    chk("CpuEn",    CpuEn,    m_mode == M_RUN);
    chk("Busy",     Busy,     m_mode == M_LOAD);
    chk("Error",    Error,    m_mode == M_ERR);
    chk("RxReady",  RxReady,  m_mode == M_LOAD && !m_have);
    chk("MemWe",    MemWe,    ewe);
    chk("MemRe",    MemRe,    ere);
    chk("MemAdr",   MemAdr,   ea);
    chk("MemWData", MemWData, ed);
    if (MemWe && !CpuEn) obs_q.push_back('{MemAdr, MemWData});
  endtask

  task automatic model_edge();
    if (Start && m_mode != M_LOAD) begin
      m_have = 0; m_quiet = 0;
      if (LenIn == 0) m_mode = M_RUN;
      else begin m_mode = M_LOAD; m_left = LenIn; m_next_adr = BASE; end
    end else if (m_mode == M_LOAD) begin
      if (Stop) begin
        m_mode = M_IDLE; m_have = 0;
      end else if (m_have) begin
        m_next_adr = (m_next_adr + 1) % 65536;
        m_left--; m_have = 0; m_quiet++;
        if (m_left == 0) m_mode = M_RUN;
      end else if (RxValid) begin
        m_byte = RxData; m_have = 1; m_quiet = 0;
      end else begin
        m_quiet++;
      end
      if (m_mode == M_LOAD && m_quiet >= TO) begin m_mode = M_ERR; m_have = 0; end
    end else if (m_mode == M_RUN && Stop) begin
      m_mode = M_IDLE;
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(negedge Clk);
    check_outputs();
    model_edge();
    @(posedge Clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    bit acc;
    acc = 0;
    RxValid = 1'b1; RxData = b;
    for (int i = 0; i < 10; i++) begin
      acc = (m_mode == M_LOAD && !m_have);
      step();
      if (acc) break;
    end
    chk("feed_accept", acc, 1'b1);
  endtask

  initial begin
    logic [15:0] exp_a [3];
    logic [7:0]  exp_d [3];
    int silence;
    model_reset();
    CpuWrtMem = 1'b1; CpuAdr = 16'hBEEF;
    #2;
    check_outputs();
    @(posedge Clk); #1;
    Rst = 1'b0; CpuWrtMem = 1'b0;

    // Three-byte back-to-back load, wrapping the address past FFFF.
    obs_q.delete();
    Start = 1'b1; LenIn = 16'd3; step(); Start = 1'b0;
    feed(8'h11); feed(8'h22); feed(8'h33);
    RxValid = 1'b0;
    step();
    chk("load3_cpuen", CpuEn, 1'b1);
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
    exp_d = '{8'h11, 8'h22, 8'h33};
    chk("load3_nwr", obs_q.size(), 3);
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      chk("load3_adr", obs_q[i].a, exp_a[i]);
      chk("load3_dat", obs_q[i].d, exp_d[i]);
    end

    // CPU pass-through then Stop.
    CpuWrtMem = 1'b1; CpuAdr = 16'h1234; CpuData = 8'h5A; #1;
    chk("run_we", MemWe, 1'b1);
    chk("run_adr", MemAdr, 16'h1234);
    chk("run_dat", MemWData, 8'h5A);
    step();
    CpuWrtMem = 1'b0; Stop = 1'b1; step(); Stop = 1'b0;
    chk("stop_cpuen", CpuEn, 1'b0);

    // Zero-length load goes straight to RUN with no write.
    obs_q.delete();
    Start = 1'b1; LenIn = 16'd0; step(); Start = 1'b0;
    chk("len0_cpuen", CpuEn, 1'b1);
    step();
    chk("len0_nwr", obs_q.size(), 0);

    // Timeout after one byte of two.
    Start = 1'b1; LenIn = 16'd2; step(); Start = 1'b0;
    feed(8'hA5);
    RxValid = 1'b0;
    repeat (TO - 1) step();
    chk("to_pre_err", Error, 1'b0);
    step();
    chk("to_err", Error, 1'b1);
    chk("to_cpuen", CpuEn, 1'b0);
    Start = 1'b1; LenIn = 16'd0; step(); Start = 1'b0;
    chk("to_clr_err", Error, 1'b0);
    chk("to_run", CpuEn, 1'b1);

    // Asynchronous reset in the middle of a load.
    Start = 1'b1; LenIn = 16'd5; step(); Start = 1'b0;
    feed(8'h5C);
    RxValid = 1'b0;
    #2 Rst = 1'b1;
    #1;
    chk("arst_busy", Busy, 1'b0);
    chk("arst_we", MemWe, 1'b0);
    chk("arst_rdy", RxReady, 1'b0);
    chk("arst_cpuen", CpuEn, 1'b0);
    chk("arst_err", Error, 1'b0);
    model_reset();
    @(posedge Clk); #1;
    Rst = 1'b0;
    step();

    // Randomized traffic.
    silence = 0;
    for (int c = 0; c < 3000; c++) begin
      Start = ($urandom_range(0, 39) == 0);
      Stop  = ($urandom_range(0, 59) == 0);
      LenIn = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      if (silence == 0 && $urandom_range(0, 99) == 0) silence = int'($urandom_range(5, 12));
      RxValid = (silence > 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
      if (silence > 0) silence--;
      RxData    = 8'($urandom);
      CpuLdMem  = 1'($urandom_range(0, 1));
      CpuWrtMem = 1'($urandom_range(0, 1));
      CpuAdr    = 16'($urandom);
      CpuData   = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
